nvme_cq_reader: RTL and testbench

NVME_CQ_READER -- requirements
Module: nvme_cq_reader

---
 rtl/nvme_pkg.sv | 36 +++
 rtl/nvme_cq_db_ctrl.sv | 87 ++++++++
 rtl/nvme_cq_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_nvme_cq_reader.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_pkg.sv
// ----------------------------------------------------------------------------
// nvme_pkg
// Shared definitions for the NVMe completion-queue reader:
//   - bit offsets of the fields inside one 16-byte completion queue entry
//   - the reader FSM state encoding
//   - cqe_t, the decoded view of one completion entry
// No ports; imported by nvme_cq_reader.
// ----------------------------------------------------------------------------
package nvme_pkg;

    localparam int CQE_W          = 128;
    localparam int CQE_SQHD_LSB   = 64;
    localparam int CQE_SQID_LSB   = 80;
    localparam int CQE_CID_LSB    = 96;
    localparam int CQE_PHASE_BIT  = 112;
    localparam int CQE_STATUS_LSB = 113;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_OUT,
        ST_DB,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [15:0] cid;
        logic [15:0] sqid;
        logic [15:0] sqhd;
        logic [14:0] status;
        logic        phase;
    } cqe_t;

endpackage

// File: rtl/nvme_cq_db_ctrl.sv
// ----------------------------------------------------------------------------
// nvme_cq_db_ctrl
// Owns the CQ head doorbell write handshake and, when doorbell coalescing is
// built in, the count of completions consumed since the last doorbell.
//
// Build option: NVME_CQ_DB_COALESCE_EN
//   defined   - a pending counter tracks consumed entries; batch_hit_o tells
//               the reader whether the entry being consumed now fills a batch
//   undefined - no counter; every consumed entry is followed by a doorbell
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   consume_i       pulse: one completion handed off this cycle
//   start_i         pulse: launch a doorbell carrying start_head_i
//   start_head_i    head value to publish
//   db_ready_i      doorbell sink ready
//   db_valid_o      doorbell valid (registered)
//   db_head_o       doorbell head value (registered)
//   done_o          doorbell handshake happening this cycle
//   pending_nz_o    at least one consumed entry not yet published
//   batch_hit_o     the entry consumed now reaches the batch threshold
// ----------------------------------------------------------------------------
module nvme_cq_db_ctrl #(
    parameter int IDX_W    = 16,
    parameter int DB_BATCH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             consume_i,
    input  logic             start_i,
    input  logic [IDX_W-1:0] start_head_i,
    input  logic             db_ready_i,
    output logic             db_valid_o,
    output logic [IDX_W-1:0] db_head_o,
    output logic             done_o,
    output logic             pending_nz_o,
    output logic             batch_hit_o
);

    logic             db_valid_q;
    logic [IDX_W-1:0] db_head_q;

    // Doorbell register: loaded on launch, held until the sink accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_valid_q <= 1'b0;
            db_head_q  <= '0;
        end else if (start_i) begin
            db_valid_q <= 1'b1;
            db_head_q  <= start_head_i;
        end else if (db_valid_q && db_ready_i) begin
            db_valid_q <= 1'b0;
        end
    end

    assign db_valid_o = db_valid_q;
    assign db_head_o  = db_head_q;
    assign done_o     = db_valid_q & db_ready_i;

`ifdef NVME_CQ_DB_COALESCE_EN
    localparam int PEND_W = (DB_BATCH > 1) ? $clog2(DB_BATCH + 1) : 1;

    logic [PEND_W-1:0] pending_q;

    // The counter never exceeds DB_BATCH because reaching it launches a
    // doorbell, and the reader consumes nothing until that doorbell is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else if (done_o) begin
            pending_q <= '0;
        end else if (consume_i) begin
            pending_q <= pending_q + PEND_W'(1);
        end
    end

    assign pending_nz_o = (pending_q != '0);
    assign batch_hit_o  = ((int'(pending_q) + 1) >= DB_BATCH);
`else
    logic unused_consume;

    assign unused_consume = consume_i;
    assign pending_nz_o   = 1'b0;
    assign batch_hit_o    = 1'b1;
`endif

endmodule

// File: rtl/nvme_cq_reader.sv
// ----------------------------------------------------------------------------
// nvme_cq_reader
// Polls an NVMe completion queue: reads the entry at the current head, checks
// its phase tag, emits valid completions in order, advances head/phase and
// publishes the new head through a doorbell write. Stale entries trigger a
// fixed idle gap before the same slot is polled again.
//
// Build option: NVME_CQ_DB_COALESCE_EN (handled in nvme_cq_db_ctrl)
//   undefined - a doorbell follows every completion
//   defined   - doorbells are batched every DB_BATCH completions, and any
//               unpublished completions are flushed before a poll gap
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_enable                  run when high
//   cfg_cq_depth                queue entries minus one
//   rd_req_valid/ready, _idx    entry read request
//   rd_rsp_valid, rd_rsp_data   entry read data (always accepted)
//   cpl_valid/ready             completion output handshake
//   cpl_cid/sqid/sqhd/status    decoded completion fields
//   db_valid/ready, db_head     CQ head doorbell write
//   head, phase                 current head index and expected phase
// ----------------------------------------------------------------------------
module nvme_cq_reader
    import nvme_pkg::*;
#(
    parameter int IDX_W    = 16,
    parameter int POLL_GAP = 32,
    parameter int DB_BATCH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic [IDX_W-1:0] cfg_cq_depth,
    output logic             rd_req_valid,
    input  logic             rd_req_ready,
    output logic [IDX_W-1:0] rd_req_idx,
    input  logic             rd_rsp_valid,
    input  logic [CQE_W-1:0] rd_rsp_data,
    output logic             cpl_valid,
    input  logic             cpl_ready,
    output logic [15:0]      cpl_cid,
    output logic [15:0]      cpl_sqid,
    output logic [15:0]      cpl_sqhd,
    output logic [14:0]      cpl_status,
    output logic             db_valid,
    input  logic             db_ready,
    output logic [IDX_W-1:0] db_head,
    output logic [IDX_W-1:0] head,
    output logic             phase
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t           state_q;
    logic [IDX_W-1:0] head_q;
    logic             phase_q;
    logic [GAP_W-1:0] gap_q;
    logic             rd_req_valid_q;
    logic [IDX_W-1:0] rd_req_idx_q;
    logic             cpl_valid_q;
    logic             gap_after_db_q;
    cqe_t             cqe_q;

    logic [IDX_W-1:0] head_d;
    logic             phase_d;
    logic             cpl_fire;
    logic             stale;
    logic             db_start;
    logic [IDX_W-1:0] db_start_head;
    logic             db_done;
    logic             pending_nz;
    logic             batch_hit;

    // The low two dwords of the entry carry command-specific data this
    // reader does not forward.
    logic [CQE_SQHD_LSB-1:0] unused_cqe_dw01;
    assign unused_cqe_dw01 = rd_rsp_data[CQE_SQHD_LSB-1:0];

    // Head/phase after consuming the current entry, plus the doorbell launch
    // decision, which the FSM and the doorbell controller must see in the
    // same cycle.
    always_comb begin
        head_d        = head_q + IDX_W'(1);
        phase_d       = phase_q;
        if (head_q == cfg_cq_depth) begin
            head_d  = '0;
            phase_d = ~phase_q;
        end
        cpl_fire      = (state_q == ST_OUT) && cpl_ready;
        stale         = (state_q == ST_CHECK) && (cqe_q.phase != phase_q);
        db_start      = (cpl_fire && batch_hit) || (stale && pending_nz);
        db_start_head = cpl_fire ? head_d : head_q;
    end

    nvme_cq_db_ctrl #(
        .IDX_W    (IDX_W),
        .DB_BATCH (DB_BATCH)
    ) u_db_ctrl (
        .clk          (clk),
        .rst          (rst),
        .consume_i    (cpl_fire),
        .start_i      (db_start),
        .start_head_i (db_start_head),
        .db_ready_i   (db_ready),
        .db_valid_o   (db_valid),
        .db_head_o    (db_head),
        .done_o       (db_done),
        .pending_nz_o (pending_nz),
        .batch_hit_o  (batch_hit)
    );

    // Reader FSM. Only one read is ever outstanding: a new request is issued
    // only after the previous entry has been checked and disposed of.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            head_q         <= '0;
            phase_q        <= 1'b1;
            gap_q          <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_idx_q   <= '0;
            cpl_valid_q    <= 1'b0;
            gap_after_db_q <= 1'b0;
            cqe_q          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        state_q        <= ST_REQ;
                        rd_req_valid_q <= 1'b1;
                        rd_req_idx_q   <= head_q;
                    end
                end

                // An accepted request always proceeds so its data is not lost;
                // disabling only withdraws a request not yet accepted.
                ST_REQ: begin
                    if (rd_req_ready) begin
                        state_q        <= ST_WAIT;
                        rd_req_valid_q <= 1'b0;
                    end else if (!cfg_enable) begin
                        state_q        <= ST_IDLE;
                        rd_req_valid_q <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (rd_rsp_valid) begin
                        state_q      <= ST_CHECK;
                        cqe_q.sqhd   <= rd_rsp_data[CQE_SQHD_LSB +: 16];
                        cqe_q.sqid   <= rd_rsp_data[CQE_SQID_LSB +: 16];
                        cqe_q.cid    <= rd_rsp_data[CQE_CID_LSB +: 16];
                        cqe_q.phase  <= rd_rsp_data[CQE_PHASE_BIT];
                        cqe_q.status <= rd_rsp_data[CQE_STATUS_LSB +: 15];
                    end
                end

                // A stale entry with unpublished completions flushes the
                // doorbell first, then takes the poll gap.
                ST_CHECK: begin
                    if (!stale) begin
                        state_q     <= ST_OUT;
                        cpl_valid_q <= 1'b1;
                    end else if (pending_nz) begin
                        state_q        <= ST_DB;
                        gap_after_db_q <= 1'b1;
                    end else begin
                        state_q <= ST_GAP;
                        gap_q   <= '0;
                    end
                end

                ST_OUT: begin
                    if (cpl_ready) begin
                        cpl_valid_q <= 1'b0;
                        head_q      <= head_d;
                        phase_q     <= phase_d;
                        if (batch_hit) begin
                            state_q        <= ST_DB;
                            gap_after_db_q <= 1'b0;
                        end else begin
                            state_q        <= ST_REQ;
                            rd_req_valid_q <= 1'b1;
                            rd_req_idx_q   <= head_d;
                        end
                    end
                end

                ST_DB: begin
                    if (db_done) begin
                        if (gap_after_db_q) begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end else if (cfg_enable) begin
                            state_q        <= ST_REQ;
                            rd_req_valid_q <= 1'b1;
                            rd_req_idx_q   <= head_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                        gap_after_db_q <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                        gap_q <= '0;
                        if (cfg_enable) begin
                            state_q        <= ST_REQ;
                            rd_req_valid_q <= 1'b1;
                            rd_req_idx_q   <= head_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_idx   = rd_req_idx_q;
    assign cpl_valid    = cpl_valid_q;
    assign cpl_cid      = cqe_q.cid;
    assign cpl_sqid     = cqe_q.sqid;
    assign cpl_sqhd     = cqe_q.sqhd;
    assign cpl_status   = cqe_q.status;
    assign head         = head_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_nvme_cq_reader.sv
// ----------------------------------------------------------------------------
// tb_nvme_cq_reader
// Directed self-checking bench for nvme_cq_reader. Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point.
// Coalescing scenarios compile in when NVME_CQ_DB_COALESCE_EN is defined.
// ----------------------------------------------------------------------------
module tb_nvme_cq_reader;

    localparam int IDX_W    = 16;
    localparam int POLL_GAP = 8;
    localparam int DB_BATCH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_enable;
    logic [IDX_W-1:0] cfg_cq_depth;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [IDX_W-1:0] rd_req_idx;
    logic             rd_rsp_valid;
    logic [127:0]     rd_rsp_data;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [15:0]      cpl_cid;
    logic [15:0]      cpl_sqid;
    logic [15:0]      cpl_sqhd;
    logic [14:0]      cpl_status;
    logic             db_valid;
    logic             db_ready;
    logic [IDX_W-1:0] db_head;
    logic [IDX_W-1:0] head;
    logic             phase;

    int n_checks = 0;
    int n_fail   = 0;

    nvme_cq_reader #(
        .IDX_W    (IDX_W),
        .POLL_GAP (POLL_GAP),
        .DB_BATCH (DB_BATCH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enable   (cfg_enable),
        .cfg_cq_depth (cfg_cq_depth),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_idx   (rd_req_idx),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_cid      (cpl_cid),
        .cpl_sqid     (cpl_sqid),
        .cpl_sqhd     (cpl_sqhd),
        .cpl_status   (cpl_status),
        .db_valid     (db_valid),
        .db_ready     (db_ready),
        .db_head      (db_head),
        .head         (head),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        cfg_enable   = 1'b0;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        cpl_ready    = 1'b0;
        db_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a read request, accept it and return the entry one
    // cycle later. Leaves the bench in the cycle after the response.
    task automatic do_read(input logic [127:0] data, output bit ok,
                           output logic [IDX_W-1:0] idx);
        int waited;
        waited = 0;
        while (rd_req_valid !== 1'b1 && waited < 500) begin
            tick();
            waited++;
        end
        ok  = (rd_req_valid === 1'b1);
        idx = rd_req_idx;
        if (ok) begin
            rd_req_ready = 1'b1;
            tick();
            rd_req_ready = 1'b0;
            rd_rsp_data  = data;
            rd_rsp_valid = 1'b1;
            tick();
            rd_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({rd_req_valid, cpl_valid, db_valid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_valids: got %b expected 000", {rd_req_valid, cpl_valid, db_valid});
        end
        n_checks++;
        if ({head, phase} !== {16'h0000, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_head_phase: got head=%h phase=%b expected head=0000 phase=1", head, phase);
        end
        n_checks++;
        if ({cpl_cid, cpl_sqid, cpl_sqhd, cpl_status, db_head} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got cid=%h sqid=%h sqhd=%h st=%h db_head=%h expected all 0",
                     cpl_cid, cpl_sqid, cpl_sqhd, cpl_status, db_head);
        end
    endtask

    task automatic test_in_order();
        logic [IDX_W-1:0] exp_head [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
        logic             exp_phase[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0]      cid;
        logic [IDX_W-1:0] idx;
        bit               ok;
        $display("[TB] in-order completions, depth 3");
        apply_reset();
        cfg_cq_depth = 16'd3;
        cfg_enable   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cid = 16'(16'h0010 + i);
            do_read({15'h0, 1'b1, cid, 16'h0001, 16'h0000, 64'h0}, ok, idx);
            n_checks++;
            if (!ok || idx !== 16'(i)) begin
                n_fail++;
                $display("[TB] FAIL inorder_req_idx[%0d]: got ok=%0d idx=%h expected idx=%h", i, ok, idx, 16'(i));
            end
            n_checks++;
            if (cpl_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL inorder_latency_early[%0d]: got cpl_valid=%b expected 0", i, cpl_valid);
            end
            tick();
            n_checks++;
            if (cpl_valid !== 1'b1 || cpl_cid !== cid) begin
                n_fail++;
                $display("[TB] FAIL inorder_cpl[%0d]: got valid=%b cid=%h expected valid=1 cid=%h", i, cpl_valid, cpl_cid, cid);
            end
            cpl_ready = 1'b1;
            tick();
            cpl_ready = 1'b0;
            n_checks++;
            if (head !== exp_head[i] || phase !== exp_phase[i]) begin
                n_fail++;
                $display("[TB] FAIL inorder_head[%0d]: got head=%h phase=%b expected head=%h phase=%b",
                         i, head, phase, exp_head[i], exp_phase[i]);
            end
`ifndef NVME_CQ_DB_COALESCE_EN
            n_checks++;
            if (db_valid !== 1'b1 || db_head !== exp_head[i]) begin
                n_fail++;
                $display("[TB] FAIL inorder_db[%0d]: got valid=%b head=%h expected valid=1 head=%h",
                         i, db_valid, db_head, exp_head[i]);
            end
            db_ready = 1'b1;
            tick();
            db_ready = 1'b0;
`else
            n_checks++;
            if (db_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL inorder_no_db[%0d]: got db_valid=%b expected 0", i, db_valid);
            end
`endif
        end
        cfg_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stale();
        logic [IDX_W-1:0] idx;
        bit               ok;
        bit               saw;
        int               n;
        $display("[TB] stale entry and poll gap");
        apply_reset();
        cfg_cq_depth = 16'd3;
        cfg_enable   = 1'b1;
        do_read({15'h0, 1'b0, 16'h0055, 16'h0002, 16'h0003, 64'h0}, ok, idx);
        n   = 0;
        saw = 1'b0;
        while (rd_req_valid !== 1'b1 && n < 200) begin
            if (cpl_valid === 1'b1 || db_valid === 1'b1) saw = 1'b1;
            tick();
            n++;
        end
        // A completion would have appeared one tick after the check cycle;
        // the retry comes POLL_GAP cycles after that slot.
        n_checks++;
        if (n !== POLL_GAP + 1 || rd_req_idx !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL stale_retry: got %0d ticks idx=%h expected %0d ticks idx=0000", n, rd_req_idx, POLL_GAP + 1);
        end
        n_checks++;
        if (saw !== 1'b0 || head !== 16'd0 || phase !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stale_quiet: got saw_valid=%b head=%h phase=%b expected 0 0000 1", saw, head, phase);
        end
        do_read({15'h0, 1'b1, 16'h0056, 16'h0002, 16'h0003, 64'h0}, ok, idx);
        tick();
        n_checks++;
        if (!ok || idx !== 16'd0 || cpl_valid !== 1'b1 || cpl_cid !== 16'h0056) begin
            n_fail++;
            $display("[TB] FAIL stale_then_valid: got ok=%0d idx=%h valid=%b cid=%h expected idx=0000 valid=1 cid=0056",
                     ok, idx, cpl_valid, cpl_cid);
        end
        cfg_enable = 1'b0;
    endtask

`ifdef NVME_CQ_DB_COALESCE_EN
    task automatic test_coalesce();
        logic [IDX_W-1:0] idx;
        bit               ok;
        bit               saw;
        int               n;
        $display("[TB] coalesced doorbell flush before gap");
        apply_reset();
        cfg_cq_depth = 16'd15;
        cfg_enable   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_read({15'h0, 1'b1, 16'(16'h0020 + i), 16'h0001, 16'h0000, 64'h0}, ok, idx);
            tick();
            cpl_ready = 1'b1;
            tick();
            cpl_ready = 1'b0;
            n_checks++;
            if (!ok || db_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL coalesce_no_db[%0d]: got ok=%0d db_valid=%b expected db_valid=0", i, ok, db_valid);
            end
        end
        do_read({15'h0, 1'b0, 16'h0099, 16'h0001, 16'h0000, 64'h0}, ok, idx);
        tick();
        n_checks++;
        if (db_valid !== 1'b1 || db_head !== 16'd5 || head !== 16'd5) begin
            n_fail++;
            $display("[TB] FAIL coalesce_db: got valid=%b db_head=%h head=%h expected 1 0005 0005", db_valid, db_head, head);
        end
        db_ready = 1'b1;
        tick();
        db_ready = 1'b0;
        n   = 0;
        saw = 1'b0;
        while (rd_req_valid !== 1'b1 && n < 200) begin
            if (db_valid === 1'b1 || cpl_valid === 1'b1) saw = 1'b1;
            tick();
            n++;
        end
        n_checks++;
        if (n !== POLL_GAP || rd_req_idx !== 16'd5 || saw !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL coalesce_gap: got %0d ticks idx=%h saw=%b expected %0d ticks idx=0005 saw=0",
                     n, rd_req_idx, saw, POLL_GAP);
        end
        cfg_enable = 1'b0;
    endtask
`endif

    task automatic test_backpressure();
        logic [IDX_W-1:0] idx;
        bit               ok;
        bit               stable;
        $display("[TB] completion and doorbell backpressure");
        apply_reset();
        cfg_cq_depth = 16'd3;
        cfg_enable   = 1'b1;
        do_read({15'h0, 1'b1, 16'h0077, 16'h0003, 16'h0009, 64'h0}, ok, idx);
        tick();
        stable = ok;
        for (int k = 0; k < 10; k++) begin
            if (cpl_valid !== 1'b1 || cpl_cid !== 16'h0077 || cpl_sqid !== 16'h0003 ||
                cpl_sqhd !== 16'h0009 || rd_req_valid !== 1'b0 || db_valid !== 1'b0)
                stable = 1'b0;
            tick();
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cpl_stall: got valid=%b cid=%h sqid=%h sqhd=%h rd_req=%b expected held 1 0077 0003 0009 0",
                     cpl_valid, cpl_cid, cpl_sqid, cpl_sqhd, rd_req_valid);
        end
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        n_checks++;
        if (cpl_valid !== 1'b0 || head !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL cpl_release: got valid=%b head=%h expected 0 0001", cpl_valid, head);
        end
`ifndef NVME_CQ_DB_COALESCE_EN
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (db_valid !== 1'b1 || db_head !== 16'd1 || rd_req_valid !== 1'b0) stable = 1'b0;
            tick();
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL db_stall: got valid=%b head=%h rd_req=%b expected held 1 0001 0", db_valid, db_head, rd_req_valid);
        end
        db_ready = 1'b1;
        tick();
        db_ready = 1'b0;
`endif
        n_checks++;
        if (db_valid !== 1'b0 || rd_req_valid !== 1'b1 || rd_req_idx !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL next_req: got db_valid=%b rd_req=%b idx=%h expected 0 1 0001", db_valid, rd_req_valid, rd_req_idx);
        end
        cfg_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [IDX_W-1:0] idx;
        bit               ok;
        bit               saw;
        int               n;
        $display("[TB] reset with a read outstanding");
        apply_reset();
        cfg_cq_depth = 16'd3;
        cfg_enable   = 1'b1;
        n = 0;
        while (rd_req_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        rd_req_ready = 1'b1;
        tick();
        rd_req_ready = 1'b0;
        tick();
        rst        = 1'b1;
        cfg_enable = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({rd_req_valid, cpl_valid, db_valid, phase, head} !== {3'b000, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL midreset_state: got valids=%b phase=%b head=%h expected 000 1 0000",
                     {rd_req_valid, cpl_valid, db_valid}, phase, head);
        end
        rd_rsp_data  = {15'h0, 1'b1, 16'h0099, 16'h0001, 16'h0000, 64'h0};
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (cpl_valid !== 1'b0 || db_valid !== 1'b0 || rd_req_valid !== 1'b0 || cpl_cid !== 16'h0000) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL late_rsp_ignored: got activity=%b cid=%h expected 0 0000", saw, cpl_cid);
        end
        cfg_enable = 1'b1;
        do_read({15'h0, 1'b1, 16'h0042, 16'h0001, 16'h0000, 64'h0}, ok, idx);
        tick();
        n_checks++;
        if (!ok || idx !== 16'd0 || cpl_valid !== 1'b1 || cpl_cid !== 16'h0042) begin
            n_fail++;
            $display("[TB] FAIL midreset_resume: got ok=%0d idx=%h valid=%b cid=%h expected idx=0000 valid=1 cid=0042",
                     ok, idx, cpl_valid, cpl_cid);
        end
        cfg_enable = 1'b0;
    endtask

    task automatic test_decode();
        logic [IDX_W-1:0] idx;
        bit               ok;
        // Top 16 bits 0x0005: status 0x0002 in [127:113], phase tag 1.
        $display("[TB] field decode");
        apply_reset();
        cfg_cq_depth = 16'd3;
        cfg_enable   = 1'b1;
        do_read(128'h0005_1234_ABCD_5678_DEAD_BEEF_CAFE_F00D, ok, idx);
        tick();
        n_checks++;
        if (!ok || cpl_valid !== 1'b1 || cpl_status !== 15'h0002) begin
            n_fail++;
            $display("[TB] FAIL decode_status: got ok=%0d valid=%b status=%h expected valid=1 status=0002", ok, cpl_valid, cpl_status);
        end
        n_checks++;
        if (cpl_cid !== 16'h1234 || cpl_sqid !== 16'hABCD || cpl_sqhd !== 16'h5678) begin
            n_fail++;
            $display("[TB] FAIL decode_fields: got cid=%h sqid=%h sqhd=%h expected 1234 abcd 5678", cpl_cid, cpl_sqid, cpl_sqhd);
        end
        cfg_enable = 1'b0;
    endtask

    initial begin
        cfg_cq_depth = 16'd3;
        test_reset();
        test_in_order();
        test_stale();
`ifdef NVME_CQ_DB_COALESCE_EN
        test_coalesce();
`endif
        test_backpressure();
        test_reset_mid();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
